uart_rx_deframer: RTL and testbench
===================================

// Module: uart_rx_deframer
// PURPOSE
//  Serial receive front end of the UART. Synchronises the Rx line and finds frames at mid-bit.
//  Checks parity, stop bits and break, then pushes one word plus error flags per frame into the RX FIFO.
//  The FIFO drives Data_Out/Data_Rdy. Also drives RTS flow control from FIFO_Full.
// PARAMETERS
//  SYSCLK_RATE  100000000  Clk frequency in Hz
//  BAUD_RATE    9600       line bit rate; CLKS_PER_BIT = SYSCLK_RATE/BAUD_RATE (integer divide), must be >= 4
//  DATA_BITS    8          data bits per frame, 1..8
//  PARITY_BIT   1          1 = even-parity bit present after data, 0 = no parity bit
//  STOP_BITS    2          stop bits per frame, 1..2
// PORTS
//  Clk        in   1          system clock
//  Rst_n      in   1          asynchronous reset, active-low
//  Rx         in   1          asynchronous serial line, idle high
//  FIFO_Full  in   1          RX FIFO cannot accept a push
//  Rx_Data    out  DATA_BITS  received word, valid with Rx_Valid, held until next push
//  Rx_Valid   out  1          one-cycle push strobe to RX FIFO
//  Rx_Error   out  3          [0] break, [1] parity, [2] frame; valid with Rx_Valid, held like Rx_Data
//  Rx_Overrun out  1          one-cycle pulse: frame completed while FIFO_Full, word dropped
//  Rx_Busy    out  1          high in any state other than IDLE
//  RTS        out  1          registered ~FIFO_Full; high = ready to receive
// BEHAVIOUR
//  Reset (async, Rst_n=0)
//   - State=IDLE; Rx_Data=0; Rx_Error=0; Rx_Valid=0; Rx_Overrun=0; Rx_Busy=0; RTS=0.
//   - Both synchroniser flops load 1.
//   - Reset mid-frame abandons the frame; no push.
//  Input sync and frame format
//   - Rx passes through a 2-flop synchroniser (rx_s); all decisions use rx_s.
//   - Frame: start(0), data MSB first, [even parity = XOR of data], STOP_BITS ones.
//  Bit timer
//   - Counter 0..CLKS_PER_BIT-1, cleared on every state transition.
//   - A bit is sampled when the counter reaches CLKS_PER_BIT-1, except in START.
//  State machine
//   - IDLE: when rx_s==0, go to START.
//   - START: at count CLKS_PER_BIT/2-1, if rx_s==0 go to DATA (bit centre aligned); else IDLE (glitch, no push).
//   - DATA: sample DATA_BITS bits MSB first into a shift register, then go to PARITY if PARITY_BIT, else STOP.
//   - PARITY: sample one bit; parity error = sampled ^ XOR(data).
//   - STOP: sample STOP_BITS bits; frame error if any sampled stop bit is 0.
//   - After the last stop sample, go to IDLE in the next cycle and push.
//   - BREAK_WAIT: entered after a break push; stay until rx_s==1, then go to IDLE.
//  Break
//   - Break = data==0, parity sample 0 (if present) and all stops 0.
//   - On break: Rx_Error=3'b001 (parity and frame flags suppressed); Rx_Data=0; next state is BREAK_WAIT, not IDLE.
//  Push
//   - Rx_Valid pulses in the cycle after the last stop sample, if FIFO_Full==0.
//   - Rx_Data/Rx_Error update in that same cycle.
//   - Errored frames are still pushed, with their flags.
//  Overrun
//   - If FIFO_Full==1 at push time: no Rx_Valid; Rx_Overrun pulses 1 cycle; Rx_Data/Rx_Error keep old values.
//  Back-to-back frames
//   - A start edge in the first cycle of IDLE is accepted.
//   - No dead cycles are required between frames beyond the stop bits.
//  RTS
//   - RTS is a 1-cycle registered copy of ~FIFO_Full.
//   - RTS never aborts a frame already in progress.
// TESTING  (SYSCLK_RATE=153600, BAUD_RATE=9600 -> CLKS_PER_BIT=16; defaults otherwise)
//  1 Valid frame: send 8'hA5, parity 0, 2 stops
//    -> one Rx_Valid, Rx_Data=8'hA5, Rx_Error=0.
//    -> Rx_Valid exactly 1 cycle after the centre sample of the last stop bit.
//  2 Parity error: send 8'hAA with parity bit 1 -> Rx_Data=8'hAA, Rx_Error=3'b010.
//    Frame error: send 8'h3C with stops 0,0 -> Rx_Data=8'h3C, Rx_Error=3'b100.
//  3 Break: hold Rx=0 for 12 bit times, then 1
//    -> one push, Rx_Data=0, Rx_Error=3'b001.
//    -> Rx_Busy stays high until Rx returns high; no second push.
//  4 Glitch: Rx low for 5 clocks
//    -> returns to IDLE, no Rx_Valid.
//    -> a following valid 8'h5A is received correctly.
//  5 Overrun/RTS: FIFO_Full=1, send 8'h11
//    -> Rx_Overrun pulse, no Rx_Valid, RTS=0 one cycle after FIFO_Full.
//    -> release FIFO_Full, send 8'h22 -> Rx_Data=8'h22.
//  6 Back-to-back 8'h00, 8'hFF with no idle gap -> two pushes in order, both error-free.
//    Assert Rst_n=0 mid-data of a third frame -> outputs at reset values, no push.

Source files
------------

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronises Rx, samples each bit at its centre, checks
// parity/stop/break and emits one push strobe per frame toward the RX FIFO.
module uart_rx_deframer #(
  parameter int SYSCLK_RATE = 100000000,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_BIT  = 1,
  parameter int STOP_BITS   = 2
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 Rx,
  input  logic                 FIFO_Full,
  output logic [DATA_BITS-1:0] Rx_Data,
  output logic                 Rx_Valid,
  output logic [2:0]           Rx_Error,
  output logic                 Rx_Overrun,
  output logic                 Rx_Busy,
  output logic                 RTS
);

  localparam int CPB = SYSCLK_RATE / BAUD_RATE;
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CPB / 2 - 1);
  localparam logic [3:0]    DBIT_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    SBIT_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BREAK_WAIT
  } state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [3:0]           bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 rx_m_q, rx_s_q;
  logic                 par_err_q, par_zero_q;
  logic                 stop_err_q, stop_zero_q;
  logic [DATA_BITS-1:0] data_q;
  logic [2:0]           err_q;
  logic                 valid_q, ovr_q, rts_q;

  logic tick, frame_err_d, brk_d;

  assign tick = (cnt_q == CNT_LAST);
  // The final stop bit is folded in combinationally so the push lands one cycle after its sample.
  assign frame_err_d = stop_err_q | ~rx_s_q;
  assign brk_d       = (shift_q == '0) & par_zero_q & stop_zero_q & ~rx_s_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      rx_m_q      <= 1'b1;
      rx_s_q      <= 1'b1;
      par_err_q   <= 1'b0;
      par_zero_q  <= 1'b1;
      stop_err_q  <= 1'b0;
      stop_zero_q <= 1'b1;
      data_q      <= '0;
      err_q       <= '0;
      valid_q     <= 1'b0;
      ovr_q       <= 1'b0;
      rts_q       <= 1'b0;
    end else begin
      rx_m_q  <= Rx;
      rx_s_q  <= rx_m_q;
      rts_q   <= ~FIFO_Full;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rx_s_q) state_q <= START;
        end
        START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q       <= '0;
            bit_q       <= '0;
            par_err_q   <= 1'b0;
            par_zero_q  <= 1'b1;
            stop_err_q  <= 1'b0;
            stop_zero_q <= 1'b1;
            state_q     <= rx_s_q ? IDLE : DATA;
          end else cnt_q <= cnt_q + 1'b1;
        end
        DATA: begin
          if (tick) begin
            cnt_q   <= '0;
            shift_q <= (shift_q << 1) | DATA_BITS'(rx_s_q);
            if (bit_q == DBIT_LAST) begin
              bit_q   <= '0;
              state_q <= (PARITY_BIT != 0) ? PARITY : STOP;
            end else bit_q <= bit_q + 1'b1;
          end else cnt_q <= cnt_q + 1'b1;
        end
        PARITY: begin
          if (tick) begin
            cnt_q      <= '0;
            par_err_q  <= rx_s_q ^ (^shift_q);
            par_zero_q <= ~rx_s_q;
            state_q    <= STOP;
          end else cnt_q <= cnt_q + 1'b1;
        end
        STOP: begin
          if (tick) begin
            cnt_q <= '0;
            if (bit_q == SBIT_LAST) begin
              if (!FIFO_Full) begin
                valid_q <= 1'b1;
                data_q  <= brk_d ? '0 : shift_q;
                err_q   <= brk_d ? 3'b001 : {frame_err_d, par_err_q, 1'b0};
              end else ovr_q <= 1'b1;
              state_q <= brk_d ? BREAK_WAIT : IDLE;
            end else begin
              bit_q       <= bit_q + 1'b1;
              stop_err_q  <= stop_err_q | ~rx_s_q;
              stop_zero_q <= stop_zero_q & ~rx_s_q;
            end
          end else cnt_q <= cnt_q + 1'b1;
        end
        BREAK_WAIT: begin
          cnt_q <= '0;
          if (rx_s_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Rx_Data    = data_q;
  assign Rx_Error   = err_q;
  assign Rx_Valid   = valid_q;
  assign Rx_Overrun = ovr_q;
  assign Rx_Busy    = (state_q != IDLE);
  assign RTS        = rts_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer at 16 clocks per bit: frame-level expectation queue
// checked every cycle, plus literal spot checks.
module tb_uart_rx_deframer;
  localparam int CPB = 16;
  localparam int NB  = 12;  // start + 8 data + parity + 2 stops

  logic       Clk, Rst_n, Rx, FIFO_Full;
  logic [7:0] Rx_Data;
  logic       Rx_Valid, Rx_Overrun, Rx_Busy, RTS;
  logic [2:0] Rx_Error;

  uart_rx_deframer #(
    .SYSCLK_RATE(153600), .BAUD_RATE(9600), .DATA_BITS(8), .PARITY_BIT(1), .STOP_BITS(2)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Rx(Rx), .FIFO_Full(FIFO_Full),
    .Rx_Data(Rx_Data), .Rx_Valid(Rx_Valid), .Rx_Error(Rx_Error),
    .Rx_Overrun(Rx_Overrun), .Rx_Busy(Rx_Busy), .RTS(RTS)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int unsigned cyc;
    bit          ovr;
    logic [7:0]  data;
    logic [2:0]  err;
  } exp_t;

  exp_t        expq[$];
  int unsigned cyc = 0;
  int          checks = 0, failures = 0, npush = 0;
  logic [7:0]  m_data = '0;
  logic [2:0]  m_err  = '0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // Every cycle: strobes must appear exactly when the model says, held values must persist.
  always @(negedge Clk) begin
    exp_t e;
    logic ev, eo;
    if (!Rst_n) begin
      expq.delete();
      m_data = '0;
      m_err  = '0;
    end else begin
      ev = 1'b0;
      eo = 1'b0;
      if (expq.size() > 0 && expq[0].cyc == cyc) begin
        e = expq.pop_front();
        if (e.ovr) eo = 1'b1;
        else begin
          ev = 1'b1;
          m_data = e.data;
          m_err  = e.err;
        end
      end
      if (Rx_Valid) npush++;
      chk("valid", Rx_Valid, ev);
      chk("overrun", Rx_Overrun, eo);
      chk("data", Rx_Data, m_data);
      chk("error", Rx_Error, m_err);
    end
  end

  // All stimulus is aligned to 2 time units after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge Clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s0, input logic s1);
    exp_t        e;
    logic [11:0] bits;
    logic        brk;
    brk    = (d == 8'h00) && !p && !s0 && !s1;
    // Centre of the last stop bit is 8 clocks into it; 2 sync flops plus the push register add 3.
    e.cyc  = cyc + CPB * (NB - 1) + CPB / 2 + 3;
    e.ovr  = FIFO_Full;
    e.data = brk ? 8'h00 : d;
    e.err  = brk ? 3'b001 : {(!s0 || !s1), p ^ (^d), 1'b0};
    expq.push_back(e);
    bits = {1'b0, d, p, s0, s1};
    for (int i = NB - 1; i >= 0; i--) begin
      Rx = bits[i];
      idle(CPB);
    end
  endtask

  initial begin
    Rx = 1'b1; FIFO_Full = 1'b0; Rst_n = 1'b0;
    idle(3);
    chk("rst_data", Rx_Data, 8'h00);
    chk("rst_err", Rx_Error, 3'b000);
    chk("rst_valid", Rx_Valid, 1'b0);
    chk("rst_ovr", Rx_Overrun, 1'b0);
    chk("rst_busy", Rx_Busy, 1'b0);
    chk("rst_rts", RTS, 1'b0);
    Rst_n = 1'b1;
    idle(5);
    chk("rts_up", RTS, 1'b1);

    send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
    idle(20);
    chk("a5_data", Rx_Data, 8'hA5);
    chk("a5_err", Rx_Error, 3'b000);

    send_frame(8'hAA, 1'b1, 1'b1, 1'b1);
    idle(20);
    chk("par_data", Rx_Data, 8'hAA);
    chk("par_err", Rx_Error, 3'b010);

    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    Rx = 1'b1;
    idle(40);
    chk("frm_data", Rx_Data, 8'h3C);
    chk("frm_err", Rx_Error, 3'b100);

    send_frame(8'h00, 1'b0, 1'b0, 1'b0);
    chk("brk_busy0", Rx_Busy, 1'b1);
    idle(30);
    chk("brk_busy1", Rx_Busy, 1'b1);
    chk("brk_data", Rx_Data, 8'h00);
    chk("brk_err", Rx_Error, 3'b001);
    Rx = 1'b1;
    idle(6);
    chk("brk_busy_end", Rx_Busy, 1'b0);

    Rx = 1'b0;
    idle(5);
    Rx = 1'b1;
    idle(4);
    chk("glitch_busy", Rx_Busy, 1'b1);
    idle(12);
    chk("glitch_idle", Rx_Busy, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
    idle(20);
    chk("5a_data", Rx_Data, 8'h5A);
    chk("5a_err", Rx_Error, 3'b000);

    FIFO_Full = 1'b1;
    chk("rts_before", RTS, 1'b1);
    idle(1);
    chk("rts_low", RTS, 1'b0);
    send_frame(8'h11, 1'b0, 1'b1, 1'b1);
    idle(20);
    chk("ovr_held", Rx_Data, 8'h5A);
    FIFO_Full = 1'b0;
    idle(5);
    chk("rts_back", RTS, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1, 1'b1);
    idle(20);
    chk("22_data", Rx_Data, 8'h22);

    send_frame(8'h00, 1'b0, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1, 1'b1);
    idle(20);
    chk("ff_data", Rx_Data, 8'hFF);
    chk("ff_err", Rx_Error, 3'b000);

    Rx = 1'b0;
    idle(CPB);
    Rx = 1'b1;
    idle(40);
    chk("mid_busy", Rx_Busy, 1'b1);
    Rst_n = 1'b0;
    #1;
    chk("mid_rst_data", Rx_Data, 8'h00);
    chk("mid_rst_err", Rx_Error, 3'b000);
    chk("mid_rst_valid", Rx_Valid, 1'b0);
    chk("mid_rst_busy", Rx_Busy, 1'b0);
    chk("mid_rst_rts", RTS, 1'b0);
    idle(3);
    Rst_n = 1'b1;
    idle(300);

    chk("pending", expq.size(), 0);
    chk("push_count", npush, 8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
